// File: rtl/fir_filter_top.sv
`timescale 1ns/1ps
// Bit-serial moving-average FIR filter.
// Serial LSB-first input words are collected in a shift register, stored in
// a circular delay line and summed by one sequential accumulator. The sum is
// divided by FIR_DEPTH with an arithmetic shift, which is a floor division.
// The result is sent out LSB-first under ready/valid flow control.
module fir_filter_top #(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_din,
    input  logic i_din_valid,
    input  logic i_ready,
    output logic o_ready,
    output logic o_dout,
    output logic o_dout_valid
);

    localparam int LOG2_DEPTH = $clog2(FIR_DEPTH);
    localparam int ACC_WIDTH  = DATA_WIDTH + LOG2_DEPTH;
    localparam int IDX_WIDTH  = $clog2(DATA_WIDTH);

    localparam logic [LOG2_DEPTH:0]  MAC_LAST = (LOG2_DEPTH + 1)'(FIR_DEPTH);
    localparam logic [IDX_WIDTH-1:0] BIT_LAST = IDX_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_SCALE,
        ST_SHIFT_OUT
    } state_t;

    state_t                        r_state;
    logic [DATA_WIDTH-1:0]         r_shreg;
    logic [DATA_WIDTH-1:0]         r_dline [FIR_DEPTH];
    logic [LOG2_DEPTH-1:0]         r_wrPtr;
    logic [LOG2_DEPTH:0]           r_macCnt;
    logic [DATA_WIDTH-1:0]         r_tap;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]         r_outReg;
    logic [IDX_WIDTH-1:0]          r_bitIdx;
    logic                          r_dout;
    logic                          r_doutValid;
    logic                          r_ready;

    logic [DATA_WIDTH-1:0]         w_newWord;
    logic signed [ACC_WIDTH-1:0]   w_tapExt;
    logic [DATA_WIDTH-1:0]         w_scaled;
    logic [IDX_WIDTH-1:0]          w_nextIdx;

    // The incoming bit enters at the MSB, so after DATA_WIDTH shifts the word
    // sits LSB-aligned. The tap is sign-extended to the accumulator width.
    // Taking the top DATA_WIDTH bits of the accumulator equals an arithmetic
    // right shift by log2(FIR_DEPTH) followed by truncation.
    assign w_newWord = {i_din, r_shreg[DATA_WIDTH-1:1]};
    assign w_tapExt  = {{LOG2_DEPTH{r_tap[DATA_WIDTH-1]}}, r_tap};
    assign w_scaled  = r_acc[LOG2_DEPTH +: DATA_WIDTH];
    assign w_nextIdx = r_bitIdx + 1'b1;

    assign o_ready      = r_ready;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_doutValid;

    // Control FSM and datapath. The delay line is read through a registered
    // tap, so the MAC phase takes one edge to fill the tap before the first
    // accumulate. All outputs are registered.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            for (int i = 0; i < FIR_DEPTH; i++) begin
                r_dline[i] <= '0;
            end
            r_wrPtr     <= '0;
            r_macCnt    <= '0;
            r_tap       <= '0;
            r_acc       <= '0;
            r_outReg    <= '0;
            r_bitIdx    <= '0;
            r_dout      <= 1'b0;
            r_doutValid <= 1'b0;
            r_ready     <= 1'b1;
        end else if (i_en) begin
            case (r_state)
                ST_IDLE: begin
                    r_shreg <= w_newWord;
                    if (i_din_valid) begin
                        r_dline[r_wrPtr] <= w_newWord;
                        r_wrPtr          <= r_wrPtr + 1'b1;
                        r_acc            <= '0;
                        r_macCnt         <= '0;
                        r_ready          <= 1'b0;
                        r_state          <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_macCnt != '0) begin
                        r_acc <= r_acc + w_tapExt;
                    end
                    if (r_macCnt == MAC_LAST) begin
                        r_state <= ST_SCALE;
                    end else begin
                        r_tap <= r_dline[r_macCnt[LOG2_DEPTH-1:0]];
                    end
                    r_macCnt <= r_macCnt + 1'b1;
                end
                ST_SCALE: begin
                    r_outReg    <= w_scaled;
                    r_dout      <= w_scaled[0];
                    r_doutValid <= 1'b0;
                    r_bitIdx    <= '0;
                    r_state     <= ST_SHIFT_OUT;
                end
                ST_SHIFT_OUT: begin
                    if (i_ready) begin
                        if (r_bitIdx == BIT_LAST) begin
                            r_dout      <= 1'b0;
                            r_doutValid <= 1'b0;
                            r_ready     <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_bitIdx    <= w_nextIdx;
                            r_dout      <= r_outReg[w_nextIdx];
                            r_doutValid <= (w_nextIdx == BIT_LAST);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_top.sv
`timescale 1ns/1ps
// Directed testbench for the bit-serial moving-average FIR filter.
module tb_fir_filter_top;

    localparam int DW       = 24;
    localparam int DEPTH    = 16;
    localparam int BASE_LAT = DEPTH + 2;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_en;
    logic i_din;
    logic i_din_valid;
    logic i_ready;
    logic o_ready;
    logic o_dout;
    logic o_dout_valid;

    int testsRun    = 0;
    int testsFailed = 0;
    int hist[DEPTH];

    fir_filter_top #(
        .DATA_WIDTH(DW),
        .FIR_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_din       (i_din),
        .i_din_valid (i_din_valid),
        .i_ready     (i_ready),
        .o_ready     (o_ready),
        .o_dout      (o_dout),
        .o_dout_valid(o_dout_valid)
    );

    // Free-running clock, 10 ns period.
    always #5 i_clk = ~i_clk;

    // Golden moving-average model: floor of the sum of the last DEPTH samples.
    function automatic logic [DW-1:0] modelStep(input logic [DW-1:0] x);
        int sum;
        logic [31:0] q;
        for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(x));
        sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += hist[i];
        q = 32'(sum >>> $clog2(DEPTH));
        return q[DW-1:0];
    endfunction

    // Holds reset low for three edges, then releases it away from the edge.
    task automatic doReset();
        i_rst       = 1'b0;
        i_en        = 1'b1;
        i_din       = 1'b0;
        i_din_valid = 1'b0;
        i_ready     = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        for (int i = 0; i < DEPTH; i++) hist[i] = 0;
    endtask

    // Shifts one word in LSB-first with valid on the MSB.
    task automatic applyStimulus(input logic [DW-1:0] x);
        for (int b = 0; b < DW; b++) begin
            i_din       = x[b];
            i_din_valid = (b == DW - 1);
            @(posedge i_clk);
            #1;
        end
        i_din       = 1'b0;
        i_din_valid = 1'b0;
    endtask

    // Sends a word and collects the filtered word, optionally stalling the
    // sink at one bit and disabling the block during MAC. Returns observations.
    task automatic runTransaction(input logic [DW-1:0] x, input int stallBit, input int stallLen,
                                  input int enOff, output logic [DW-1:0] y, output int lowCycles,
                                  output int validErrs, output int holdErrs, output int readyErrs);
        int n;
        int waited;
        logic expValid;
        y = '0;
        validErrs = 0;
        holdErrs  = 0;
        readyErrs = 0;
        waited    = 0;
        while (o_ready !== 1'b1 && waited < 100) begin
            @(posedge i_clk);
            #1;
            waited++;
        end
        if (o_ready !== 1'b1) readyErrs++;
        applyStimulus(x);
        n = 0;
        while (n < BASE_LAT + enOff) begin
            if (o_ready !== 1'b0 || o_dout_valid !== 1'b0) readyErrs++;
            if (enOff > 0 && n == 5) begin
                i_en = 1'b0;
                repeat (enOff) begin
                    @(posedge i_clk);
                    #1;
                    n++;
                end
                i_en = 1'b1;
            end
            @(posedge i_clk);
            #1;
            n++;
        end
        for (int b = 0; b < DW; b++) begin
            expValid = (b == DW - 1);
            y[b] = o_dout;
            if (o_dout_valid !== expValid) validErrs++;
            if (o_ready !== 1'b0) readyErrs++;
            if (b == stallBit) begin
                i_ready = 1'b0;
                repeat (stallLen) begin
                    @(posedge i_clk);
                    #1;
                    n++;
                    if (o_dout !== y[b] || o_dout_valid !== expValid || o_ready !== 1'b0) holdErrs++;
                end
                i_ready = 1'b1;
            end
            @(posedge i_clk);
            #1;
            n++;
        end
        if (o_ready !== 1'b1 || o_dout !== 1'b0 || o_dout_valid !== 1'b0) readyErrs++;
        lowCycles = n;
    endtask

    // Outputs while reset is held and right after release.
    task automatic test_reset();
        i_rst       = 1'b0;
        i_en        = 1'b1;
        i_din       = 1'b0;
        i_din_valid = 1'b0;
        i_ready     = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        testsRun++;
        if (o_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready_in: got %b expected 1", o_ready);
        end
        testsRun++;
        if (o_dout !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_dout_in: got %b expected 0", o_dout);
        end
        testsRun++;
        if (o_dout_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid_in: got %b expected 0", o_dout_valid);
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        testsRun++;
        if (o_ready !== 1'b1 || o_dout !== 1'b0 || o_dout_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got ready=%b dout=%b valid=%b expected 1,0,0",
                     o_ready, o_dout, o_dout_valid);
        end
    endtask

    // Impulse of 16 spreads as 1 over sixteen outputs, then drops to 0.
    task automatic test_impulse();
        logic [DW-1:0] y;
        logic [DW-1:0] expY;
        int low, vE, hE, rE;
        doReset();
        for (int k = 0; k < DEPTH + 1; k++) begin
            runTransaction((k == 0) ? 24'h000010 : 24'h000000, -1, 0, 0, y, low, vE, hE, rE);
            expY = (k < DEPTH) ? 24'h000001 : 24'h000000;
            testsRun++;
            if (y !== expY || vE != 0 || rE != 0) begin
                testsFailed++;
                $display("[TB] FAIL impulse_%0d: got %h (verr=%0d rerr=%0d) expected %h", k, y, vE, rE, expY);
            end
        end
    endtask

    // Negative input floors toward minus infinity; DC input ramps up.
    task automatic test_negative_dc();
        logic [DW-1:0] y;
        logic [DW-1:0] expY;
        int low, vE, hE, rE;
        doReset();
        runTransaction(24'hFFFFF0, -1, 0, 0, y, low, vE, hE, rE);
        testsRun++;
        if (y !== 24'hFFFFFF) begin
            testsFailed++;
            $display("[TB] FAIL negative: got %h expected ffffff", y);
        end
        doReset();
        for (int k = 1; k <= DEPTH; k++) begin
            runTransaction(24'h100000, -1, 0, 0, y, low, vE, hE, rE);
            expY = 24'(k * 24'h010000);
            testsRun++;
            if (y !== expY) begin
                testsFailed++;
                $display("[TB] FAIL dc_ramp_%0d: got %h expected %h", k, y, expY);
            end
        end
    endtask

    // Sink stall mid-word, and busy-window length with the sink always ready.
    task automatic test_handshake();
        logic [DW-1:0] y;
        int low, vE, hE, rE;
        doReset();
        runTransaction(24'h123456, 10, 5, 0, y, low, vE, hE, rE);
        testsRun++;
        if (y !== 24'h012345) begin
            testsFailed++;
            $display("[TB] FAIL stall_value: got %h expected 012345", y);
        end
        testsRun++;
        if (hE != 0) begin
            testsFailed++;
            $display("[TB] FAIL stall_hold: got %0d hold errors expected 0", hE);
        end
        testsRun++;
        if (vE != 0 || rE != 0) begin
            testsFailed++;
            $display("[TB] FAIL stall_flags: got verr=%0d rerr=%0d expected 0,0", vE, rE);
        end
        testsRun++;
        if (low != BASE_LAT + DW + 5) begin
            testsFailed++;
            $display("[TB] FAIL stall_busy: got %0d cycles expected %0d", low, BASE_LAT + DW + 5);
        end
        runTransaction(24'h000020, -1, 0, 0, y, low, vE, hE, rE);
        testsRun++;
        if (y !== 24'h012347) begin
            testsFailed++;
            $display("[TB] FAIL second_value: got %h expected 012347", y);
        end
        testsRun++;
        if (low != BASE_LAT + DW || rE != 0) begin
            testsFailed++;
            $display("[TB] FAIL busy_window: got %0d cycles (rerr=%0d) expected %0d", low, rE, BASE_LAT + DW);
        end
    endtask

    // Clock enable dropped during MAC stretches latency, result unchanged.
    task automatic test_enable();
        logic [DW-1:0] y;
        int low, vE, hE, rE;
        doReset();
        runTransaction(24'hABCDE0, -1, 0, 10, y, low, vE, hE, rE);
        testsRun++;
        if (y !== 24'hFABCDE) begin
            testsFailed++;
            $display("[TB] FAIL enable_value: got %h expected fabcde", y);
        end
        testsRun++;
        if (low != BASE_LAT + DW + 10 || rE != 0 || vE != 0) begin
            testsFailed++;
            $display("[TB] FAIL enable_latency: got %0d cycles (rerr=%0d verr=%0d) expected %0d",
                     low, rE, vE, BASE_LAT + DW + 10);
        end
    endtask

    // Reset during serialization aborts at once and wipes the history.
    task automatic test_reset_abort();
        logic [DW-1:0] y;
        int low, vE, hE, rE;
        doReset();
        runTransaction(24'h100000, -1, 0, 0, y, low, vE, hE, rE);
        testsRun++;
        if (y !== 24'h010000) begin
            testsFailed++;
            $display("[TB] FAIL abort_pre: got %h expected 010000", y);
        end
        applyStimulus(24'h100000);
        repeat (BASE_LAT + 6) begin
            @(posedge i_clk);
            #1;
        end
        testsRun++;
        if (o_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_busy: got ready=%b expected 0", o_ready);
        end
        i_rst = 1'b0;
        #1;
        testsRun++;
        if (o_ready !== 1'b1 || o_dout !== 1'b0 || o_dout_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_async: got ready=%b dout=%b valid=%b expected 1,0,0",
                     o_ready, o_dout, o_dout_valid);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        runTransaction(24'h000010, -1, 0, 0, y, low, vE, hE, rE);
        testsRun++;
        if (y !== 24'h000001) begin
            testsFailed++;
            $display("[TB] FAIL abort_impulse0: got %h expected 000001", y);
        end
        runTransaction(24'h000000, -1, 0, 0, y, low, vE, hE, rE);
        testsRun++;
        if (y !== 24'h000001) begin
            testsFailed++;
            $display("[TB] FAIL abort_impulse1: got %h expected 000001", y);
        end
    endtask

    // Two periods of a 220-sample sine against the golden model.
    task automatic test_sine();
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] expY;
        int low, vE, hE, rE;
        int flagErrs;
        int xi;
        real r;
        doReset();
        flagErrs = 0;
        for (int n = 0; n < 440; n++) begin
            r  = 7500000.0 * $sin(6.283185307179586 * n / 220.0);
            xi = $rtoi(r);
            x  = xi[DW-1:0];
            expY = modelStep(x);
            runTransaction(x, -1, 0, 0, y, low, vE, hE, rE);
            flagErrs += vE + rE;
            testsRun++;
            if (y !== expY) begin
                testsFailed++;
                $display("[TB] FAIL sine_%0d: got %h expected %h", n, y, expY);
            end
        end
        testsRun++;
        if (flagErrs != 0) begin
            testsFailed++;
            $display("[TB] FAIL sine_flags: got %0d flag errors expected 0", flagErrs);
        end
    endtask

    // Runs all scenarios in order and prints the summary.
    initial begin
        test_reset();
        test_impulse();
        test_negative_dc();
        test_handshake();
        test_enable();
        test_reset_abort();
        test_sine();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Guards against a run that never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
